// File: rtl/sound_ram_arbiter.sv
// ---------------------------------------------------------------------------
// sound_ram_arbiter
//
// Shares the 64 KB single-port synchronous sound RAM between the DOC
// wavetable fetch port and the sound GLU host port. Each DOC cycle (one
// doc_enable pulse) is divided into phases by a 4-bit counter `ph`.
//
// Slot schedule (outputs are registered, so each entry is what the RAM
// sees while `ph` holds that value):
//   ph 0 : DOC read address on ram_addr (if a fetch is pending)
//   ph 1 : ram_q carries the DOC byte; it is captured on the ph 1 -> 2 edge
//   ph 2 : doc_fetch_valid pulses; buffered host write drives ram_we
//   ph 3 : sound_addr on ram_addr (host read prefetch)
//   ph 4 : ram_q carries the prefetch byte; captured into host_rd
//   ph 5+: glu_rd_data shows the prefetched byte (when ram_access = 1)
//
// Parameters:
//   FRAME_MIN  phases a frame needs for all slots to complete. A doc_enable
//              arriving while ph < FRAME_MIN abandons the remaining slots.
//              Must be at least 5 so that the slots never overlap a restart.
//
// Ports:
//   clk              system clock (14 MHz, shared with the GLU)
//   reset_n          synchronous active-low reset
//   doc_enable       GLU frame pulse, one per DOC cycle
//   ram_access       GLU mode: 1 = sound RAM, 0 = DOC registers
//   sound_addr       GLU address pointer
//   sound_data_out   GLU write data
//   ram_wr           GLU RAM write strobe
//   doc_reg_data     DOC register read data
//   doc_fetch_req    DOC wavetable read request
//   doc_fetch_addr   DOC fetch address (sampled with doc_fetch_req)
//   doc_fetch_data   fetched byte
//   doc_fetch_valid  one-cycle pulse qualifying doc_fetch_data
//   glu_rd_data      data returned to the GLU sound_data_in port
//   ram_addr         RAM address
//   ram_din          RAM write data
//   ram_we           RAM write enable
//   ram_q            RAM read data, valid one cycle after its address
//   wbuf_ovf         sticky: a buffered host write was lost before commit
//
// Optional feature macro: SOUND_RAM_FWD_EN
//   When defined, a DOC fetch whose address matches the pending host write
//   buffer at the ph 0 slot returns the buffered byte instead of the stale
//   RAM contents. The write still commits at ph 2 in either build.
// ---------------------------------------------------------------------------
module sound_ram_arbiter #(
  parameter int FRAME_MIN = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        doc_enable,
  input  logic        ram_access,
  input  logic [15:0] sound_addr,
  input  logic [7:0]  sound_data_out,
  input  logic        ram_wr,
  input  logic [7:0]  doc_reg_data,
  input  logic        doc_fetch_req,
  input  logic [15:0] doc_fetch_addr,
  output logic [7:0]  doc_fetch_data,
  output logic        doc_fetch_valid,
  output logic [7:0]  glu_rd_data,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  input  logic [7:0]  ram_q,
  output logic        wbuf_ovf
);

  localparam logic [3:0] PH_IDLE = 4'd15;

  // Phase counter
  logic [3:0]  ph;
  logic [3:0]  ph_d;

  // DOC request capture
  logic        doc_pend;
  logic        doc_pend_d;
  logic [15:0] doc_addr;
  logic [15:0] doc_addr_d;
  logic        doc_taken;
  logic        doc_taken_d;

  // Host write buffer
  logic        wb_full;
  logic        wb_full_d;
  logic [15:0] wb_addr;
  logic [15:0] wb_addr_d;
  logic [7:0]  wb_data;
  logic [7:0]  wb_data_d;

  // Host read prefetch result
  logic [7:0]  host_rd;
  logic [7:0]  host_rd_d;

  // Registered outputs, next values
  logic [15:0] ram_addr_d;
  logic [7:0]  ram_din_d;
  logic        ram_we_d;
  logic [7:0]  doc_fetch_data_d;
  logic        doc_fetch_valid_d;
  logic [7:0]  glu_rd_data_d;
  logic        wbuf_ovf_d;

  // Slot decode
  logic        short_frame;
  logic        slot_doc_issue;
  logic        slot_doc_done;
  logic        slot_wr_commit;
  logic        slot_prefetch;
  logic        slot_host_done;

  // Byte delivered to the DOC when its fetch completes
  logic [7:0]  doc_read_byte;

  // A frame pulse arriving before FRAME_MIN phases have elapsed cuts the
  // frame short. Every completion slot below is gated with it, so an
  // abandoned slot neither clears its pending flag nor touches the RAM.
  assign short_frame = doc_enable && (int'({28'd0, ph}) < FRAME_MIN);

  // Each slot strobe fires on the clock edge that enters the phase in which
  // its effect must be visible, which is why they decode the phase before.
  assign slot_doc_issue = doc_enable && doc_pend;
  assign slot_doc_done  = (ph == 4'd1) && doc_taken && !short_frame;
  assign slot_wr_commit = (ph == 4'd1) && wb_full && !short_frame;
  assign slot_prefetch  = (ph == 4'd2) && !short_frame;
  assign slot_host_done = (ph == 4'd4) && !short_frame;

`ifdef SOUND_RAM_FWD_EN
  // Forwarding decision is taken at the ph 0 slot alongside the DOC read,
  // and the buffered byte is held until the fetch completes, so a later
  // overwrite of the buffer cannot change what this fetch returns.
  logic        fwd_hit;
  logic        fwd_hit_d;
  logic [7:0]  fwd_data;
  logic [7:0]  fwd_data_d;

  always_comb begin
    fwd_hit_d  = fwd_hit;
    fwd_data_d = fwd_data;
    if (slot_doc_issue) begin
      fwd_hit_d  = wb_full && (wb_addr == doc_addr);
      fwd_data_d = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fwd_hit  <= 1'b0;
      fwd_data <= 8'd0;
    end else begin
      fwd_hit  <= fwd_hit_d;
      fwd_data <= fwd_data_d;
    end
  end

  assign doc_read_byte = fwd_hit ? fwd_data : ram_q;
`else
  assign doc_read_byte = ram_q;
`endif

  // Phase counter: restart on the frame pulse, otherwise count up and park
  // at the idle value.
  always_comb begin
    ph_d = ph;
    if (doc_enable) begin
      ph_d = 4'd0;
    end else if (ph != PH_IDLE) begin
      ph_d = ph + 4'd1;
    end
  end

  // Request capture. Completion clears a flag, but a capture in the same
  // cycle is applied afterwards so the new request survives to next frame.
  always_comb begin
    doc_pend_d  = doc_pend;
    doc_addr_d  = doc_addr;
    doc_taken_d = doc_taken;
    wb_full_d   = wb_full;
    wb_addr_d   = wb_addr;
    wb_data_d   = wb_data;
    wbuf_ovf_d  = wbuf_ovf;

    if (doc_enable) begin
      doc_taken_d = doc_pend;
    end else if (slot_doc_done) begin
      doc_taken_d = 1'b0;
    end

    if (slot_doc_done) begin
      doc_pend_d = 1'b0;
    end
    if (doc_fetch_req) begin
      doc_pend_d = 1'b1;
      doc_addr_d = doc_fetch_addr;
    end

    if (slot_wr_commit) begin
      wb_full_d = 1'b0;
    end
    if (ram_wr) begin
      wb_full_d = 1'b1;
      wb_addr_d = sound_addr;
      wb_data_d = sound_data_out;
      // The buffered byte is only lost if it is not committing this cycle.
      if (wb_full && !slot_wr_commit) begin
        wbuf_ovf_d = 1'b1;
      end
    end
  end

  // RAM port and result registers. ram_addr and ram_din hold between slots.
  always_comb begin
    ram_addr_d        = ram_addr;
    ram_din_d         = ram_din;
    ram_we_d          = 1'b0;
    doc_fetch_data_d  = doc_fetch_data;
    doc_fetch_valid_d = 1'b0;
    host_rd_d         = host_rd;

    if (slot_doc_issue) begin
      ram_addr_d = doc_addr;
    end
    if (slot_wr_commit) begin
      ram_addr_d = wb_addr;
      ram_din_d  = wb_data;
      ram_we_d   = 1'b1;
    end
    if (slot_prefetch) begin
      ram_addr_d = sound_addr;
    end

    if (slot_doc_done) begin
      doc_fetch_data_d  = doc_read_byte;
      doc_fetch_valid_d = 1'b1;
    end
    if (slot_host_done) begin
      host_rd_d = ram_q;
    end
  end

  // The GLU mux uses the new host_rd value so the prefetch is visible from
  // ph 5 rather than one cycle later.
  assign glu_rd_data_d = ram_access ? host_rd_d : doc_reg_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ph              <= PH_IDLE;
      doc_pend        <= 1'b0;
      doc_addr        <= 16'd0;
      doc_taken       <= 1'b0;
      wb_full         <= 1'b0;
      wb_addr         <= 16'd0;
      wb_data         <= 8'd0;
      wbuf_ovf        <= 1'b0;
      host_rd         <= 8'd0;
      ram_addr        <= 16'd0;
      ram_din         <= 8'd0;
      ram_we          <= 1'b0;
      doc_fetch_data  <= 8'd0;
      doc_fetch_valid <= 1'b0;
      glu_rd_data     <= 8'd0;
    end else begin
      ph              <= ph_d;
      doc_pend        <= doc_pend_d;
      doc_addr        <= doc_addr_d;
      doc_taken       <= doc_taken_d;
      wb_full         <= wb_full_d;
      wb_addr         <= wb_addr_d;
      wb_data         <= wb_data_d;
      wbuf_ovf        <= wbuf_ovf_d;
      host_rd         <= host_rd_d;
      ram_addr        <= ram_addr_d;
      ram_din         <= ram_din_d;
      ram_we          <= ram_we_d;
      doc_fetch_data  <= doc_fetch_data_d;
      doc_fetch_valid <= doc_fetch_valid_d;
      glu_rd_data     <= glu_rd_data_d;
    end
  end

endmodule

// File: tb/tb_sound_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sound_ram_arbiter
//
// Bench for sound_ram_arbiter with a behavioural synchronous RAM attached.
// Expected DOC fetch bytes and expected RAM writes are queued as stimulus is
// issued; monitors pop and compare whenever doc_fetch_valid or ram_we is
// seen. tb_ph tracks the frame phase independently of the DUT.
// ---------------------------------------------------------------------------
module tb_sound_ram_arbiter;

  localparam int OP_DOC     = 0;
  localparam int OP_WR      = 1;
  localparam int OP_PRELOAD = 2;
  localparam int OP_FRAME   = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        doc_enable;
  logic        ram_access;
  logic [15:0] sound_addr;
  logic [7:0]  sound_data_out;
  logic        ram_wr;
  logic [7:0]  doc_reg_data;
  logic        doc_fetch_req;
  logic [15:0] doc_fetch_addr;
  logic [7:0]  doc_fetch_data;
  logic        doc_fetch_valid;
  logic [7:0]  glu_rd_data;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_q;
  logic        wbuf_ovf;

  logic        preload_we;
  logic [15:0] preload_addr;
  logic [7:0]  preload_data;
  logic [7:0]  mem [0:65535];

  logic [3:0]  tb_ph;
  logic [7:0]  doc_exp_q [$];
  logic [23:0] wr_exp_q [$];
  logic [7:0]  dexp;
  logic [23:0] wexp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sound_ram_arbiter #(.FRAME_MIN(5)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .doc_enable     (doc_enable),
    .ram_access     (ram_access),
    .sound_addr     (sound_addr),
    .sound_data_out (sound_data_out),
    .ram_wr         (ram_wr),
    .doc_reg_data   (doc_reg_data),
    .doc_fetch_req  (doc_fetch_req),
    .doc_fetch_addr (doc_fetch_addr),
    .doc_fetch_data (doc_fetch_data),
    .doc_fetch_valid(doc_fetch_valid),
    .glu_rd_data    (glu_rd_data),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .ram_we         (ram_we),
    .ram_q          (ram_q),
    .wbuf_ovf       (wbuf_ovf)
  );

  // Single-port synchronous RAM, read-before-write, plus a bench preload path
  always @(posedge clk) begin
    if (preload_we) mem[preload_addr] <= preload_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_q <= mem[ram_addr];
  end

  // Reference frame phase: 0 on the cycle after doc_enable, saturating at 15
  always @(posedge clk) begin
    if (!reset_n) tb_ph <= 4'd15;
    else if (doc_enable) tb_ph <= 4'd0;
    else if (tb_ph != 4'd15) tb_ph <= tb_ph + 4'd1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Monitors run on the falling edge, away from the DUT's active edge
  always @(negedge clk) begin
    if (doc_fetch_valid) begin
      if (doc_exp_q.size() == 0) begin
        checkOutput("doc_valid_unexpected", 32'(doc_fetch_valid), 32'h0);
      end else begin
        dexp = doc_exp_q.pop_front();
        checkOutput("doc_valid_phase", 32'(tb_ph), 32'h2);
        checkOutput("doc_fetch_data", 32'(doc_fetch_data), 32'(dexp));
      end
    end
    if (ram_we) begin
      if (wr_exp_q.size() == 0) begin
        checkOutput("ram_we_unexpected", 32'(ram_we), 32'h0);
      end else begin
        wexp = wr_exp_q.pop_front();
        checkOutput("ram_we_phase", 32'(tb_ph), 32'h2);
        checkOutput("ram_we_addr", 32'(ram_addr), 32'(wexp[23:8]));
        checkOutput("ram_we_din", 32'(ram_din), 32'(wexp[7:0]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitPh(input logic [3:0] k);
    int n = 0;
    while (tb_ph != k && n < 40) begin
      tick(1);
      n++;
    end
    if (tb_ph != k) checkOutput("wait_phase_timeout", 32'(tb_ph), 32'(k));
  endtask

  task automatic applyStimulus(input int kind, input logic [15:0] addr,
                               input logic [7:0] data);
    case (kind)
      OP_DOC: begin
        doc_fetch_req  = 1'b1;
        doc_fetch_addr = addr;
        tick(1);
        doc_fetch_req  = 1'b0;
      end
      OP_WR: begin
        ram_wr         = 1'b1;
        sound_addr     = addr;
        sound_data_out = data;
        tick(1);
        ram_wr         = 1'b0;
      end
      OP_PRELOAD: begin
        preload_we   = 1'b1;
        preload_addr = addr;
        preload_data = data;
        tick(1);
        preload_we   = 1'b0;
      end
      default: begin
        doc_enable = 1'b1;
        tick(1);
        doc_enable = 1'b0;
      end
    endcase
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    doc_enable     = 1'b0;
    ram_access     = 1'b0;
    sound_addr     = 16'h0;
    sound_data_out = 8'h0;
    ram_wr         = 1'b0;
    doc_reg_data   = 8'h0;
    doc_fetch_req  = 1'b1;
    doc_fetch_addr = 16'h4444;
    preload_we     = 1'b0;
    preload_addr   = 16'h0;
    preload_data   = 8'h0;

    // Reset with a fetch request held: everything zero, request dropped
    tick(3);
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'h0);
    checkOutput("rst_ram_din", 32'(ram_din), 32'h0);
    checkOutput("rst_ram_we", 32'(ram_we), 32'h0);
    checkOutput("rst_doc_data", 32'(doc_fetch_data), 32'h0);
    checkOutput("rst_doc_valid", 32'(doc_fetch_valid), 32'h0);
    checkOutput("rst_glu_rd", 32'(glu_rd_data), 32'h0);
    checkOutput("rst_wbuf_ovf", 32'(wbuf_ovf), 32'h0);
    checkOutput("rst_ph", 32'(dut.ph), 32'hF);
    doc_fetch_req = 1'b0;
    reset_n       = 1'b1;
    tick(1);
    applyStimulus(OP_FRAME, 16'h0, 8'h0);
    waitPh(4'd15);

    applyStimulus(OP_PRELOAD, 16'h1234, 8'h5A);
    applyStimulus(OP_PRELOAD, 16'h2000, 8'h11);

    // DOC register path on the GLU read mux
    doc_reg_data = 8'h3C;
    tick(2);
    checkOutput("glu_rd_doc_reg", 32'(glu_rd_data), 32'h3C);

    // Plain DOC fetch
    doc_exp_q.push_back(8'h5A);
    applyStimulus(OP_DOC, 16'h1234, 8'h0);
    applyStimulus(OP_FRAME, 16'h0, 8'h0);
    checkOutput("doc_addr_ph0", 32'(ram_addr), 32'h1234);
    checkOutput("doc_we_ph0", 32'(ram_we), 32'h0);
    waitPh(4'd15);

    // Host write landing at ph 0, then read back by the ph 3 prefetch
    applyStimulus(OP_FRAME, 16'h0, 8'h0);
    wr_exp_q.push_back({16'h0100, 8'hC3});
    applyStimulus(OP_WR, 16'h0100, 8'hC3);
    ram_access = 1'b1;
    waitPh(4'd3);
    checkOutput("prefetch_addr_ph3", 32'(ram_addr), 32'h0100);
    waitPh(4'd5);
    checkOutput("glu_rd_host_ph5", 32'(glu_rd_data), 32'hC3);
    ram_access = 1'b0;
    waitPh(4'd15);

    // Same-address collision, then a second fetch proves the RAM holds 0x77
    wr_exp_q.push_back({16'h2000, 8'h77});
`ifdef SOUND_RAM_FWD_EN
    doc_exp_q.push_back(8'h77);
`else
    doc_exp_q.push_back(8'h11);
`endif
    applyStimulus(OP_WR, 16'h2000, 8'h77);
    applyStimulus(OP_DOC, 16'h2000, 8'h0);
    applyStimulus(OP_FRAME, 16'h0, 8'h0);
    waitPh(4'd15);
    doc_exp_q.push_back(8'h77);
    applyStimulus(OP_DOC, 16'h2000, 8'h0);
    applyStimulus(OP_FRAME, 16'h0, 8'h0);
    waitPh(4'd15);

    // Write buffer overflow: only the second byte commits, flag is sticky
    applyStimulus(OP_WR, 16'h0300, 8'hAA);
    checkOutput("ovf_single_write", 32'(wbuf_ovf), 32'h0);
    wr_exp_q.push_back({16'h0300, 8'hBB});
    applyStimulus(OP_WR, 16'h0300, 8'hBB);
    checkOutput("ovf_set", 32'(wbuf_ovf), 32'h1);
    applyStimulus(OP_FRAME, 16'h0, 8'h0);
    waitPh(4'd15);
    checkOutput("ovf_sticky", 32'(wbuf_ovf), 32'h1);

    // Short frame at ph 1: both slots retried in the following frame
    doc_exp_q.push_back(8'h5A);
    wr_exp_q.push_back({16'h0400, 8'h5C});
    applyStimulus(OP_DOC, 16'h1234, 8'h0);
    applyStimulus(OP_WR, 16'h0400, 8'h5C);
    applyStimulus(OP_FRAME, 16'h0, 8'h0);
    tick(1);
    checkOutput("short_ph1_we", 32'(ram_we), 32'h0);
    applyStimulus(OP_FRAME, 16'h0, 8'h0);
    checkOutput("short_restart_we", 32'(ram_we), 32'h0);
    waitPh(4'd15);

    // Reset mid-frame drops both pending requests
    applyStimulus(OP_DOC, 16'h1234, 8'h0);
    applyStimulus(OP_WR, 16'h0500, 8'h99);
    applyStimulus(OP_FRAME, 16'h0, 8'h0);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    checkOutput("midrst_ram_addr", 32'(ram_addr), 32'h0);
    checkOutput("midrst_ovf", 32'(wbuf_ovf), 32'h0);
    applyStimulus(OP_FRAME, 16'h0, 8'h0);
    waitPh(4'd15);

    tick(4);
    checkOutput("doc_queue_drained", 32'(doc_exp_q.size()), 32'h0);
    checkOutput("wr_queue_drained", 32'(wr_exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
